// File: rtl/agc_pkg.sv
// Shared types and helpers for the dB-domain AGC: FSM state encoding and a saturating clamp.
package agc_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        EVAL,
        REQ,
        SETTLE
    } agc_state_e;

    function automatic int sat_clamp(input int value, input int lo, input int hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/peak_window_tracker.sv
// Running maximum over EVAL_LEN valid samples; done fires combinationally with the last sample.
module peak_window_tracker #(
    parameter int DW       = 12,
    parameter int EVAL_LEN = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] sample,
    input  logic                 valid,
    input  logic                 clear,
    output logic signed [DW-1:0] peak,
    output logic                 done
);

    localparam int CW = (EVAL_LEN > 1) ? $clog2(EVAL_LEN) : 1;
    localparam logic signed [DW-1:0] PEAK_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [CW-1:0]        cnt_reg;
    logic signed [DW-1:0] peak_reg;

    assign done = valid && !clear && (cnt_reg == CW'(EVAL_LEN - 1));
    assign peak = peak_reg;

    // Clear wins over a coincident sample so a disabled or busy window never accumulates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg  <= '0;
            peak_reg <= PEAK_MIN;
        end else if (clear) begin
            cnt_reg  <= '0;
            peak_reg <= PEAK_MIN;
        end else if (valid) begin
            if (sample > peak_reg) peak_reg <= sample;
            cnt_reg <= done ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/gain_ctrl_agc.sv
// Closed-loop AGC: windowed peak vs. hysteresis band, clamped gain requests over valid/ready.
// Optional AGC_PROPORTIONAL_EN: step = clamp(TARGET-peak, +/-MAX_STEP) instead of +/-GAIN_STEP.
module gain_ctrl_agc
    import agc_pkg::*;
#(
    parameter int DW         = 12,
    parameter int GW         = 8,
    parameter int LOW_RANGE  = -30,
    parameter int HIGH_RANGE = -10,
    parameter int TARGET     = -20,
    parameter int GAIN_MIN   = -10,
    parameter int GAIN_MAX   = 40,
    parameter int GAIN_INIT  = 0,
    parameter int GAIN_STEP  = 2,
    parameter int MAX_STEP   = 8,
    parameter int EVAL_LEN   = 1024,
    parameter int SETTLE_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] level_db_i,
    input  logic                 valid_i,
    input  logic                 enable_i,
    input  logic                 set_ready_i,
    output logic signed [GW-1:0] gain_db_o,
    output logic                 set_gain_o,
    output logic                 sat_o
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    if (LOW_RANGE >= HIGH_RANGE) begin : g_bad_range
        $error("gain_ctrl_agc: LOW_RANGE must be below HIGH_RANGE");
    end
    if (GAIN_INIT < GAIN_MIN || GAIN_INIT > GAIN_MAX) begin : g_bad_init
        $error("gain_ctrl_agc: GAIN_INIT outside [GAIN_MIN,GAIN_MAX]");
    end
    if (EVAL_LEN < 1 || SETTLE_CYC < 1) begin : g_bad_len
        $error("gain_ctrl_agc: EVAL_LEN and SETTLE_CYC must be >= 1");
    end
    // Step parameters of both modes are sanity-checked in every build.
    if (GAIN_STEP < 1 || MAX_STEP < 1 || TARGET < LOW_RANGE || TARGET > HIGH_RANGE) begin : g_bad_step
        $error("gain_ctrl_agc: invalid GAIN_STEP/MAX_STEP/TARGET");
    end

    agc_state_e           state_reg, state_next;
    logic signed [GW-1:0] gain_reg, gain_next;
    logic                 set_gain_reg, set_gain_next;
    logic [SW-1:0]        settle_cnt_reg, settle_cnt_next;

    logic signed [DW-1:0] peak;
    logic                 win_done;
    logic                 win_clear;
    logic signed [GW+1:0] delta_hi, delta_lo, delta, sum;
    logic signed [GW-1:0] gain_cand;

    // The window only accumulates in ACCUM with the loop enabled; every other state wipes it.
    assign win_clear = (state_reg != ACCUM) || !enable_i;

    peak_window_tracker #(
        .DW      (DW),
        .EVAL_LEN(EVAL_LEN)
    ) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .sample(level_db_i),
        .valid (valid_i),
        .clear (win_clear),
        .peak  (peak),
        .done  (win_done)
    );

`ifdef AGC_PROPORTIONAL_EN
    localparam logic signed [DW:0] TARGET_W = (DW+1)'(TARGET);
    logic signed [DW:0] err;
    assign err      = TARGET_W - $signed({peak[DW-1], peak});
    assign delta_hi = (GW+2)'(sat_clamp(int'(err), -MAX_STEP, MAX_STEP));
    assign delta_lo = delta_hi;
`else
    assign delta_hi = -$signed((GW+2)'(GAIN_STEP));
    assign delta_lo = (GW+2)'(GAIN_STEP);
`endif

    always_comb begin
        delta = '0;
        if (int'(peak) > HIGH_RANGE)     delta = delta_hi;
        else if (int'(peak) < LOW_RANGE) delta = delta_lo;
    end

    assign sum       = $signed({{2{gain_reg[GW-1]}}, gain_reg}) + delta;
    assign gain_cand = GW'(sat_clamp(int'(sum), GAIN_MIN, GAIN_MAX));

    always_comb begin
        state_next      = state_reg;
        gain_next       = gain_reg;
        set_gain_next   = set_gain_reg;
        settle_cnt_next = settle_cnt_reg;
        case (state_reg)
            ACCUM: begin
                if (win_done) state_next = EVAL;
            end
            EVAL: begin
                // A clamped result equal to the current gain is not worth a register write.
                if (enable_i && (gain_cand != gain_reg)) begin
                    gain_next     = gain_cand;
                    set_gain_next = 1'b1;
                    state_next    = REQ;
                end else begin
                    state_next = ACCUM;
                end
            end
            REQ: begin
                if (set_ready_i) begin
                    set_gain_next   = 1'b0;
                    settle_cnt_next = '0;
                    state_next      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_reg == SW'(SETTLE_CYC - 1)) begin
                    settle_cnt_next = '0;
                    state_next      = ACCUM;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ACCUM;
            gain_reg       <= GW'(GAIN_INIT);
            set_gain_reg   <= 1'b0;
            settle_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            gain_reg       <= gain_next;
            set_gain_reg   <= set_gain_next;
            settle_cnt_reg <= settle_cnt_next;
        end
    end

    assign gain_db_o  = gain_reg;
    assign set_gain_o = set_gain_reg;
    assign sat_o      = (gain_reg == GW'(GAIN_MIN)) || (gain_reg == GW'(GAIN_MAX));

endmodule

// File: tb/tb_gain_ctrl_agc.sv
// Self-checking bench for gain_ctrl_agc (EVAL_LEN=8, SETTLE_CYC=4): vector table plus corner sequences.
module tb_gain_ctrl_agc;

    localparam int DW = 12;
    localparam int GW = 8;
`ifdef AGC_PROPORTIONAL_EN
    localparam bit PROP = 1'b1;
`else
    localparam bit PROP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic signed [DW-1:0] level_db_i = '0;
    logic                 valid_i = 1'b0;
    logic                 enable_i = 1'b1;
    logic                 set_ready_i = 1'b1;
    logic signed [GW-1:0] gain_db_o;
    logic                 set_gain_o;
    logic                 sat_o;

    always #5 clk = ~clk;

    gain_ctrl_agc #(
        .DW        (DW),
        .GW        (GW),
        .EVAL_LEN  (8),
        .SETTLE_CYC(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .level_db_i (level_db_i),
        .valid_i    (valid_i),
        .enable_i   (enable_i),
        .set_ready_i(set_ready_i),
        .gain_db_o  (gain_db_o),
        .set_gain_o (set_gain_o),
        .sat_o      (sat_o)
    );

    typedef struct {
        int peak;
        int exp_gain;
        int exp_sat;
    } vec_t;

    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;
    int   exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One clock: mid-cycle handshake scoreboard, then land 2ns after the rising edge.
    task automatic step();
        @(negedge clk);
        if (rst && set_gain_o && set_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL xfer_unexpected: got transfer gain=%0d, required none", gain_db_o);
            end else begin
                check("xfer_gain", int'(gain_db_o), exp_q.pop_front());
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    // Eight valid samples whose maximum is exactly peak; scatter puts it at a random slot.
    task automatic window(input int peak, input bit scatter);
        int pos;
        pos = int'($urandom_range(0, 7));
        valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (scatter && i != pos) level_db_i = DW'(peak - int'($urandom_range(1, 40)));
            else                     level_db_i = DW'(peak);
            step();
        end
        valid_i = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_gain"}, int'(gain_db_o), 0);
        check({tag, "_set"}, int'(set_gain_o), 0);
        check({tag, "_sat"}, int'(sat_o), 0);
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        int cur;
        int exp_g;
        int st;

        vecs[0] = '{-20, 0, 0};
        vecs[1] = '{-10, 0, 0};
        vecs[2] = '{-30, 0, 0};
        if (!PROP) begin
            vecs[3] = '{-5,   -2, 0};
            vecs[4] = '{-9,   -4, 0};
            vecs[5] = '{-31,  -2, 0};
            vecs[6] = '{-100,  0, 0};
        end else begin
            vecs[3] = '{-5,   -8, 0};
            vecs[4] = '{-9,  -10, 1};
            vecs[5] = '{-31,  -2, 0};
            vecs[6] = '{-100,  6, 0};
        end

        #1;
        check("por_gain", int'(gain_db_o), 0);
        check("por_set", int'(set_gain_o), 0);
        check("por_sat", int'(sat_o), 0);
        step();
        rst = 1'b1;
        step();

        // Table: one window per record, scoreboard expects a transfer whenever gain moves.
        cur = 0;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_gain != cur) exp_q.push_back(vecs[i].exp_gain);
            window(vecs[i].peak, i[0]);
            drain(8);
            check($sformatf("vec%0d_gain", i), int'(gain_db_o), vecs[i].exp_gain);
            check($sformatf("vec%0d_sat", i), int'(sat_o), vecs[i].exp_sat);
            cur = vecs[i].exp_gain;
        end
        reset_check("rst_a");

        // Latency and exact settle length.
        exp_g = PROP ? -8 : -2;
        exp_q.push_back(exp_g);
        valid_i = 1'b1;
        level_db_i = DW'(-5);
        repeat (8) step();
        valid_i = 1'b0;
        check("lat_eval_set", int'(set_gain_o), 0);
        step();
        check("lat_req_set", int'(set_gain_o), 1);
        check("lat_req_gain", int'(gain_db_o), exp_g);
        valid_i = 1'b1;
        level_db_i = DW'(-20);
        step();
        check("lat_drop_set", int'(set_gain_o), 0);
        repeat (4) step();
        level_db_i = DW'(-50);
        exp_q.push_back(0);
        repeat (8) step();
        valid_i = 1'b0;
        check("settle_eval_set", int'(set_gain_o), 0);
        step();
        check("settle_req_set", int'(set_gain_o), 1);
        check("settle_req_gain", int'(gain_db_o), 0);
        drain(8);

        // enable_i low clears a half-filled window.
        valid_i = 1'b1;
        level_db_i = DW'(-5);
        repeat (4) step();
        enable_i = 1'b0;
        step();
        enable_i = 1'b1;
        level_db_i = DW'(-20);
        repeat (8) step();
        valid_i = 1'b0;
        drain(8);
        check("en_gain", int'(gain_db_o), 0);
        check("en_queue", exp_q.size(), 0);

        // Saturation at GAIN_MAX.
        st = PROP ? 8 : 2;
        exp_g = 0;
        while (exp_g < 40) begin
            exp_g = (exp_g + st > 40) ? 40 : exp_g + st;
            exp_q.push_back(exp_g);
            window(-50, 1'b1);
            drain(8);
            check("sat_step_gain", int'(gain_db_o), exp_g);
        end
        window(-50, 1'b0);
        drain(8);
        check("sat_hold_gain", int'(gain_db_o), 40);
        check("sat_flag", int'(sat_o), 1);
        check("sat_queue", exp_q.size(), 0);
        reset_check("rst_b");

        // Back-pressure: request held, samples ignored, single transfer.
        set_ready_i = 1'b0;
        exp_g = PROP ? -8 : -2;
        exp_q.push_back(exp_g);
        window(-5, 1'b0);
        step();
        valid_i = 1'b1;
        level_db_i = DW'(-50);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_set", int'(set_gain_o), 1);
            check("bp_hold_gain", int'(gain_db_o), exp_g);
            step();
        end
        valid_i = 1'b0;
        set_ready_i = 1'b1;
        step();
        check("bp_after_set", int'(set_gain_o), 0);
        drain(8);
        check("bp_queue", exp_q.size(), 0);

        // Reset while a request is pending drops it.
        set_ready_i = 1'b0;
        exp_g = PROP ? -10 : -4;
        window(-5, 1'b0);
        step();
        check("rq_set", int'(set_gain_o), 1);
        check("rq_gain", int'(gain_db_o), exp_g);
        reset_check("rst_req");
        set_ready_i = 1'b1;
        drain(12);
        check("rq_after_set", int'(set_gain_o), 0);
        check("rq_after_gain", int'(gain_db_o), 0);
        check("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
